snake_dir_input: RTL

- Front-end input stage feeding the game controller's move logic with the snake's heading.
- Per button: synchronises and debounces four raw push buttons, then turns each press into a direction request.
- Drops illegal requests (same heading or 180° reversal) and queues legal ones in a small FIFO.
- The game controller pops one queued turn per move tick via a single-cycle step strobe.

---
 rtl/snake_dir_input.sv | 131 +++++++++++++
 1 files changed

// File: rtl/snake_dir_input.sv
// Snake heading input stage: sync + debounce 4 buttons, filter illegal turns, queue legal ones (SNAKE_DIR_DROP_CNT_EN adds drop_cnt).
// Latency: raw edge to queue entry 2+DEBOUNCE_CYCLES cycles; step pops to dir_out/turn_pulse next cycle.
// Backpressure: none upstream; a legal turn arriving at a full queue without a coincident step is dropped.
module snake_dir_input #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int QDEPTH_LOG2     = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             btn_raw,
   input  logic                   step,
   input  logic                   restart,
   output logic [1:0]             dir_out,
   output logic                   turn_pulse,
   output logic [QDEPTH_LOG2:0]   q_count
`ifdef SNAKE_DIR_DROP_CNT_EN
   ,
   output logic [7:0]             drop_cnt
`endif
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int DEPTH = 1 << QDEPTH_LOG2;
   localparam int QC_W  = QDEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
   localparam logic [QC_W-1:0]        QC_FULL  = QC_W'(DEPTH);
   localparam logic [QC_W-1:0]        QC_ONE   = QC_W'(1);
   localparam logic [QDEPTH_LOG2-1:0] PTR_ONE  = QDEPTH_LOG2'(1);

   logic [3:0]             sync1, sync2, deb;
   logic [CNT_W-1:0]       cnt [4];
   logic [3:0]             flip, rise;
   logic [1:0]             mem [DEPTH];
   logic [QDEPTH_LOG2-1:0] head, tail, tail_last;
   logic                   cand_vld, legal, full, accepted, do_pop, do_push;
   logic [1:0]             cand, ref_dir;

   // A press is taken on the same edge that the debounced state rises.
   always_comb begin
      flip = 4'b0000;
      rise = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         flip[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_LAST);
         rise[i] = flip[i] & ~deb[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 4'b0000;
         sync2 <= 4'b0000;
         deb   <= 4'b0000;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (flip[i]) begin
               cnt[i] <= '0;
               deb[i] <= ~deb[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      cand_vld  = |rise;
      cand      = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
      tail_last = tail - PTR_ONE;
      ref_dir   = (q_count != '0) ? mem[tail_last] : dir_out;
      legal     = (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
      full      = (q_count == QC_FULL);
      accepted  = legal && (!full || step);
      do_pop    = step && (q_count != '0) && !restart;
      do_push   = cand_vld && accepted && !restart;
   end

   // On a full queue with push+pop, tail equals head; the head is read before it is overwritten.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_out    <= 2'b01;
         turn_pulse <= 1'b0;
         q_count    <= '0;
         head       <= '0;
         tail       <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
      end else if (restart) begin
         dir_out    <= 2'b01;
         turn_pulse <= 1'b0;
         q_count    <= '0;
         head       <= '0;
         tail       <= '0;
      end else begin
         turn_pulse <= do_pop && (mem[head] != dir_out);
         if (do_pop) begin
            dir_out <= mem[head];
            head    <= head + PTR_ONE;
         end
         if (do_push) begin
            mem[tail] <= cand;
            tail      <= tail + PTR_ONE;
         end
         if (do_push && !do_pop)      q_count <= q_count + QC_ONE;
         else if (do_pop && !do_push) q_count <= q_count - QC_ONE;
      end
   end

`ifdef SNAKE_DIR_DROP_CNT_EN
   logic [2:0] n_press, discards;
   logic [8:0] drop_sum;

   always_comb begin
      n_press  = {2'b00, rise[0]} + {2'b00, rise[1]} + {2'b00, rise[2]} + {2'b00, rise[3]};
      discards = (cand_vld ? (n_press - 3'd1) : 3'd0) + {2'b00, cand_vld & ~accepted};
      drop_sum = {1'b0, drop_cnt} + {6'b000000, discards};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          drop_cnt <= 8'd0;
      else if (restart)   drop_cnt <= 8'd0;
      else if (drop_sum[8]) drop_cnt <= 8'hFF;
      else                drop_cnt <= drop_sum[7:0];
   end
`endif

endmodule
